// File: rtl/ederah_counter_pkg.sv
// Shared types and arithmetic for the ederah kernel counter bank.
package ederah_counter_pkg;

    typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;

    localparam logic [31:0] LP_ZERO = 32'd0;
    localparam logic [31:0] LP_ONE  = 32'd1;

    // All-ones mask for a lane of the given width (up to 32 bits).
    function automatic logic [31:0] lp_max(input int width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (LP_ONE << width) - LP_ONE;
    endfunction

    // Returns {event, value}: event flags a wrap or clamp, value is already reduced to width bits.
    function automatic logic [32:0] next_count(input logic [31:0] count,
                                               input logic [31:0] step,
                                               input logic        up,
                                               input cnt_mode_e   mode,
                                               input int          width);
        logic [33:0] sum;
        logic [31:0] mx;
        logic [32:0] res;
        mx  = lp_max(width);
        res = '0;
        sum = {2'b00, count} + {2'b00, step};
        if (up) begin
            if (sum > {2'b00, mx}) begin
                res[32]   = 1'b1;
                res[31:0] = (mode == CNT_SAT) ? mx : (sum[31:0] & mx);
            end else begin
                res[31:0] = sum[31:0];
            end
        end else begin
            if (step > count) begin
                res[32]   = 1'b1;
                res[31:0] = (mode == CNT_SAT) ? LP_ZERO : ((count - step) & mx);
            end else begin
                res[31:0] = count - step;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ederah_counter_lane.sv
// One counter lane: count register, registered flags, optional sticky overflow
// (enabled by defining EDERAH_COUNTER_BANK_OVF_EN).
module ederah_counter_lane
    import ederah_counter_pkg::*;
#(
    parameter int                 C_WIDTH    = 8,
    parameter int                 C_STEP_W   = 1,
    parameter int                 C_SATURATE = 0,
    parameter logic [C_WIDTH-1:0] C_INIT     = {C_WIDTH{1'b0}},
    parameter logic [C_WIDTH-1:0] C_THRESH   = {C_WIDTH{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clken,
    input  logic                load,
    input  logic                incr,
    input  logic                decr,
    input  logic [C_STEP_W-1:0] step,
    input  logic [C_WIDTH-1:0]  load_value,
    input  logic                ovf_clr,
    output logic [C_WIDTH-1:0]  count,
    output logic                is_zero,
    output logic                is_max,
    output logic                at_thresh,
    output logic                ovf
);

    localparam cnt_mode_e   LP_MODE    = (C_SATURATE != 0) ? CNT_SAT : CNT_WRAP;
    localparam logic [31:0] LP_MAX32   = lp_max(C_WIDTH);
    localparam logic [C_WIDTH-1:0] LP_MAX_W  = LP_MAX32[C_WIDTH-1:0];
    localparam logic [C_WIDTH-1:0] LP_ZERO_W = LP_ZERO[C_WIDTH-1:0];

    logic [32:0]        arith;
    logic [C_WIDTH-1:0] next_value;
    logic               wrap_event;
    logic               unused_arith;

    // Simultaneous incr and decr cancel out and leave the lane untouched.
    always_comb begin
        arith      = next_count(32'(count), 32'(step), incr, LP_MODE, C_WIDTH);
        next_value = count;
        wrap_event = 1'b0;
        if (load) begin
            next_value = load_value;
        end else if (incr ^ decr) begin
            next_value = arith[C_WIDTH-1:0];
            wrap_event = arith[32];
        end
    end

    assign unused_arith = ^arith;

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= C_INIT;
            is_zero   <= (C_INIT == LP_ZERO_W);
            is_max    <= (C_INIT == LP_MAX_W);
            at_thresh <= (C_INIT >= C_THRESH);
        end else if (clken) begin
            count     <= next_value;
            is_zero   <= (next_value == LP_ZERO_W);
            is_max    <= (next_value == LP_MAX_W);
            at_thresh <= (next_value >= C_THRESH);
        end
    end

`ifdef EDERAH_COUNTER_BANK_OVF_EN
    // A new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clken) begin
            if (wrap_event) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr ^ wrap_event;
    assign ovf        = 1'b0;
`endif

endmodule

// File: rtl/ederah_kernel_counter_bank.sv
// Bank of independent up/down counter lanes with shared clock enable and an all-zero summary.
// Sticky overflow flags are built only when EDERAH_COUNTER_BANK_OVF_EN is defined.
module ederah_kernel_counter_bank
    import ederah_counter_pkg::*;
#(
    parameter int                 C_CHANNELS = 4,
    parameter int                 C_WIDTH    = 8,
    parameter int                 C_STEP_W   = 1,
    parameter int                 C_SATURATE = 0,
    parameter logic [C_WIDTH-1:0] C_INIT     = {C_WIDTH{1'b0}},
    parameter logic [C_WIDTH-1:0] C_THRESH   = {C_WIDTH{1'b1}}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clken,
    input  logic [C_CHANNELS-1:0]          load,
    input  logic [C_CHANNELS-1:0]          incr,
    input  logic [C_CHANNELS-1:0]          decr,
    input  logic [C_CHANNELS*C_STEP_W-1:0] step,
    input  logic [C_CHANNELS*C_WIDTH-1:0]  load_value,
    input  logic [C_CHANNELS-1:0]          ovf_clr,
    output logic [C_CHANNELS*C_WIDTH-1:0]  count,
    output logic [C_CHANNELS-1:0]          is_zero,
    output logic [C_CHANNELS-1:0]          is_max,
    output logic [C_CHANNELS-1:0]          at_thresh,
    output logic                           all_zero,
    output logic [C_CHANNELS-1:0]          ovf
);

    for (genvar i = 0; i < C_CHANNELS; i++) begin : g_lane
        ederah_counter_lane #(
            .C_WIDTH    (C_WIDTH),
            .C_STEP_W   (C_STEP_W),
            .C_SATURATE (C_SATURATE),
            .C_INIT     (C_INIT),
            .C_THRESH   (C_THRESH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .clken      (clken),
            .load       (load[i]),
            .incr       (incr[i]),
            .decr       (decr[i]),
            .step       (step[i*C_STEP_W +: C_STEP_W]),
            .load_value (load_value[i*C_WIDTH +: C_WIDTH]),
            .ovf_clr    (ovf_clr[i]),
            .count      (count[i*C_WIDTH +: C_WIDTH]),
            .is_zero    (is_zero[i]),
            .is_max     (is_max[i]),
            .at_thresh  (at_thresh[i]),
            .ovf        (ovf[i])
        );
    end

    assign all_zero = &is_zero;

endmodule

// File: tb/tb_ederah_kernel_counter_bank.sv
// Scoreboard bench: one wrap-mode and one saturate-mode bank driven in parallel
// against an integer reference model; honours EDERAH_COUNTER_BANK_OVF_EN.
module tb_ederah_kernel_counter_bank;

`ifdef EDERAH_COUNTER_BANK_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clken = 1'b0;
    logic [3:0]  load = '0, incr = '0, decr = '0, ovf_clr = '0;
    logic [11:0] step = '0;
    logic [31:0] load_value = '0;

    logic [31:0] count_w, count_s;
    logic [3:0]  iz_w, iz_s, im_w, im_s, at_w, at_s, ov_w, ov_s;
    logic        az_w, az_s;

    typedef struct packed {
        logic [31:0] cnt;
        logic [3:0]  iz;
        logic [3:0]  im;
        logic [3:0]  at;
        logic [3:0]  ov;
        logic        az;
    } exp_t;

    typedef struct packed {
        exp_t w;
        exp_t s;
    } pair_t;

    pair_t exp_q[$];
    int    m_cnt[2][4];
    bit    m_ovf[2][4];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    ederah_kernel_counter_bank #(
        .C_CHANNELS(4), .C_WIDTH(8), .C_STEP_W(3), .C_SATURATE(0),
        .C_INIT(8'h00), .C_THRESH(8'h04)
    ) dut_wrap (
        .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
        .step(step), .load_value(load_value), .ovf_clr(ovf_clr),
        .count(count_w), .is_zero(iz_w), .is_max(im_w), .at_thresh(at_w),
        .all_zero(az_w), .ovf(ov_w)
    );

    ederah_kernel_counter_bank #(
        .C_CHANNELS(4), .C_WIDTH(8), .C_STEP_W(3), .C_SATURATE(1),
        .C_INIT(8'h00), .C_THRESH(8'h04)
    ) dut_sat (
        .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
        .step(step), .load_value(load_value), .ovf_clr(ovf_clr),
        .count(count_s), .is_zero(iz_s), .is_max(im_s), .at_thresh(at_s),
        .all_zero(az_s), .ovf(ov_s)
    );

    // Expected outputs derived from the model's integer counts.
    function automatic exp_t buildExpect(input int k);
        exp_t e;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            e.cnt[i*8 +: 8] = 8'(m_cnt[k][i]);
            e.iz[i] = (m_cnt[k][i] == 0);
            e.im[i] = (m_cnt[k][i] == 255);
            e.at[i] = (m_cnt[k][i] >= 4);
            e.ov[i] = m_ovf[k][i];
        end
        e.az = &e.iz;
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input logic ce, input logic [3:0] ld,
                                 input logic [3:0] inc, input logic [3:0] dec,
                                 input logic [3:0] clr, input logic [11:0] stp,
                                 input logic [31:0] lv);
        int t;
        int s;
        bit ev;
        @(negedge clk);
        rst = r; clken = ce; load = ld; incr = inc; decr = dec;
        ovf_clr = clr; step = stp; load_value = lv;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (r) begin
                    m_cnt[k][i] = 0;
                    m_ovf[k][i] = 1'b0;
                end else if (ce) begin
                    ev = 1'b0;
                    s  = int'(stp[i*3 +: 3]);
                    if (ld[i]) begin
                        m_cnt[k][i] = int'(lv[i*8 +: 8]);
                    end else if (inc[i] != dec[i]) begin
                        t = inc[i] ? m_cnt[k][i] + s : m_cnt[k][i] - s;
                        if (t > 255 || t < 0) begin
                            ev = 1'b1;
                            if (k == 1) m_cnt[k][i] = (t > 255) ? 255 : 0;
                            else        m_cnt[k][i] = ((t % 256) + 256) % 256;
                        end else begin
                            m_cnt[k][i] = t;
                        end
                    end
                    if (OVF_EN) begin
                        if (ev)          m_ovf[k][i] = 1'b1;
                        else if (clr[i]) m_ovf[k][i] = 1'b0;
                    end
                end
            end
        end
        exp_q.push_back('{w: buildExpect(0), s: buildExpect(1)});
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation is retired per clock, sampled after the edge settles.
    initial begin
        pair_t p;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                p = exp_q.pop_front();
                checkOutput("wrap.count",    count_w,       p.w.cnt);
                checkOutput("wrap.is_zero",  32'(iz_w),     32'(p.w.iz));
                checkOutput("wrap.is_max",   32'(im_w),     32'(p.w.im));
                checkOutput("wrap.at_thresh",32'(at_w),     32'(p.w.at));
                checkOutput("wrap.all_zero", 32'(az_w),     32'(p.w.az));
                checkOutput("wrap.ovf",      32'(ov_w),     32'(p.w.ov));
                checkOutput("sat.count",     count_s,       p.s.cnt);
                checkOutput("sat.is_zero",   32'(iz_s),     32'(p.s.iz));
                checkOutput("sat.is_max",    32'(im_s),     32'(p.s.im));
                checkOutput("sat.at_thresh", 32'(at_s),     32'(p.s.at));
                checkOutput("sat.all_zero",  32'(az_s),     32'(p.s.az));
                checkOutput("sat.ovf",       32'(ov_s),     32'(p.s.ov));
            end
        end
    end

    function automatic logic [7:0] pickValue();
        case ($urandom_range(0, 6))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'hFE;
            3: return 8'hFF;
            4: return 8'h03;
            5: return 8'h04;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] lv;
        logic        r;
        // Reset
        applyStimulus(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 32'h0);
        applyStimulus(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 32'h0);
        // Lane 0 wraps / clamps upward
        applyStimulus(0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 12'h000, 32'h0000_00FE);
        applyStimulus(0, 1, 4'h0, 4'h1, 4'h0, 4'h0, 12'h003, 32'h0);
        // Lane 1 goes below zero twice, then clear its overflow
        applyStimulus(0, 1, 4'h2, 4'h0, 4'h0, 4'h0, 12'h000, 32'h0000_0200);
        applyStimulus(0, 1, 4'h0, 4'h0, 4'h2, 4'h0, 12'h028, 32'h0);
        applyStimulus(0, 1, 4'h0, 4'h0, 4'h2, 4'h0, 12'h028, 32'h0);
        applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 32'h0);
        applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h2, 12'h000, 32'h0);
        // Lane 2: load beats incr, incr+decr holds, clken low holds
        applyStimulus(0, 1, 4'h4, 4'h4, 4'h0, 4'h0, 12'h040, 32'h0010_0000);
        applyStimulus(0, 1, 4'h0, 4'h4, 4'h4, 4'h0, 12'h040, 32'h0);
        applyStimulus(0, 0, 4'h0, 4'h4, 4'h0, 4'h0, 12'h040, 32'h0);
        // Lane 3 climbs through the threshold and back
        for (int n = 0; n < 5; n++) begin
            applyStimulus(0, 1, 4'h0, 4'h8, 4'h0, 4'h0, 12'h200, 32'h0);
        end
        applyStimulus(0, 1, 4'h0, 4'h0, 4'h8, 4'h0, 12'h200, 32'h0);
        applyStimulus(0, 1, 4'h0, 4'h0, 4'h8, 4'h0, 12'h200, 32'h0);
        // Reset while every lane is counting
        applyStimulus(0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 12'h000, 32'h3333_3333);
        applyStimulus(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 12'h249, 32'h0);
        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) lv[i*8 +: 8] = pickValue();
            r = ($urandom_range(0, 99) < 2);
            applyStimulus(r, ($urandom_range(0, 9) != 0),
                          4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
                          4'($urandom), 4'($urandom),
                          4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                          12'($urandom), lv);
        end
        // Drain the scoreboard with a bounded wait
        for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
            @(posedge clk);
            #4;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
